speaker_arbiter: RTL and testbench

Shares the single 1-bit `speaker` pin between the background-music tone stream and N sound-effect requesters, such as hit, block and KO cues from the fight logic. Each requester issues a one-cycle request carrying a tone half-period and a duration. The arbiter grants by fixed priority, allows a higher-priority effect to preempt a lower one, and generates the effect's square wave itself. Between an effect and the return of music it inserts a silent guard gap. It sits between the BGM generator and the top-level speaker output.

---
 rtl/speaker_arbiter_if.sv | 31 +++
 rtl/speaker_arbiter.sv | 168 ++++++++++++++++
 tb/tb_speaker_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/speaker_arbiter_if.sv
// Bundle between the sound-effect requesters, the BGM generator and the speaker arbiter.
// The arbiter attaches through the slave modport; the driving side uses master.
interface speaker_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int HALF_W = 20,
    parameter int LEN_W  = 28
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                    bgm_in;
    logic                    bgm_en;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*HALF_W-1:0] req_half;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic                    speaker;
    logic                    busy;
    logic [ID_W-1:0]         active_id;
    logic                    grant;
    logic                    done;
    logic [N_REQ-1:0]        drop;

    modport master (
        output bgm_in, bgm_en, req, req_half, req_len,
        input  speaker, busy, active_id, grant, done, drop
    );

    modport slave (
        input  bgm_in, bgm_en, req, req_half, req_len,
        output speaker, busy, active_id, grant, done, drop
    );
endinterface

// File: rtl/speaker_arbiter.sv
// Fixed-priority owner of the speaker pin: BGM when idle, preemptible effect tones
// generated locally, and a silent guard gap before music returns.
module speaker_arbiter #(
    parameter int N_REQ      = 4,
    parameter int HALF_W     = 20,
    parameter int LEN_W      = 28,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    speaker_arbiter_if.slave  bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] hc_q, hc_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [GAP_W-1:0]  gc_q, gc_d;
    logic              speaker_q, speaker_d;
    logic              busy_q, busy_d;
    logic              grant_q, grant_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   active_id_q, active_id_d;
    logic [N_REQ-1:0]  drop_q, drop_d;

    logic [HALF_W-1:0] half_arr [N_REQ];
    logic [LEN_W-1:0]  len_arr  [N_REQ];
    logic [N_REQ-1:0]  win_onehot;
    logic              any_req;
    logic [ID_W-1:0]   win_id;
    logic [HALF_W-1:0] win_half;
    logic [LEN_W-1:0]  win_len;
    logic              finishing;
    logic              accept;
    logic              tone_flip;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign half_arr[gi]   = bus.req_half[gi*HALF_W +: HALF_W];
            assign len_arr[gi]    = bus.req_len[gi*LEN_W +: LEN_W];
            assign win_onehot[gi] = any_req && (win_id == ID_W'(gi));
        end
    endgenerate

    // Lowest set index wins; scanning downward leaves the smallest index last.
    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                any_req = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    assign win_half  = half_arr[win_id];
    assign win_len   = (len_arr[win_id] == '0) ? LEN_W'(1) : len_arr[win_id];
    assign finishing = (state_q == ST_PLAY) && (rem_q == LEN_W'(1));
    // A finishing effect is never defended on priority: its slot is free anyway.
    assign accept    = any_req && ((state_q != ST_PLAY) || finishing || (win_id < active_id_q));
    assign tone_flip = (half_q != '0) && (hc_q == half_q - HALF_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            half_q      <= '0;
            hc_q        <= '0;
            rem_q       <= '0;
            gc_q        <= '0;
            speaker_q   <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= 1'b0;
            done_q      <= 1'b0;
            active_id_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            hc_q        <= hc_d;
            rem_q       <= rem_d;
            gc_q        <= gc_d;
            speaker_q   <= speaker_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            active_id_q <= active_id_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        hc_d    = hc_q;
        rem_d   = rem_q;
        gc_d    = gc_q;
        if (accept) begin
            state_d = ST_PLAY;
            half_d  = win_half;
            rem_d   = win_len;
            hc_d    = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (finishing) begin
                        hc_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gc_d    = GAP_W'(GAP_CYCLES);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                        if (half_q != '0) begin
                            hc_d = tone_flip ? '0 : hc_q + HALF_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gc_q == GAP_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        gc_d = gc_q - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant_d     = accept;
        done_d      = finishing;
        active_id_d = accept ? win_id : active_id_q;
        busy_d      = (state_d != ST_IDLE);
        drop_d      = bus.req & ~win_onehot;
        if (any_req && !accept) begin
            drop_d = drop_d | win_onehot;
        end
        speaker_d = 1'b0;
        if (accept) begin
            speaker_d = (win_half != '0);
        end else begin
            case (state_q)
                ST_IDLE: speaker_d = bus.bgm_in & bus.bgm_en;
                ST_PLAY: speaker_d = finishing ? 1'b0 : (speaker_q ^ tone_flip);
                default: speaker_d = 1'b0;
            endcase
        end
    end

    assign bus.speaker   = speaker_q;
    assign bus.busy      = busy_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.active_id = active_id_q;
    assign bus.drop      = drop_q;
endmodule

// File: tb/tb_speaker_arbiter.sv
// Directed bench for speaker_arbiter with a 5-cycle guard gap; expected values are
// hand-derived from the cycle-level behaviour of the arbiter.
module tb_speaker_arbiter;
    localparam int N_REQ  = 4;
    localparam int HALF_W = 20;
    localparam int LEN_W  = 28;
    localparam int GAP    = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    speaker_arbiter_if #(.N_REQ(N_REQ), .HALF_W(HALF_W), .LEN_W(LEN_W)) bus ();

    speaker_arbiter #(
        .N_REQ(N_REQ), .HALF_W(HALF_W), .LEN_W(LEN_W), .GAP_CYCLES(GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int idx, input int half, input int len);
        bus.req_half[idx*HALF_W +: HALF_W] = HALF_W'(half);
        bus.req_len[idx*LEN_W +: LEN_W]    = LEN_W'(len);
    endtask

    task automatic fire(input logic [N_REQ-1:0] r);
        bus.req = r;
        step();
        bus.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pat;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.bgm_in   = 1'b1;
        bus.bgm_en   = 1'b1;
        bus.req      = '0;
        bus.req_half = '0;
        bus.req_len  = '0;

        steps(2);
        check("rst_speaker", bus.speaker, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_drop", bus.drop, 0);
        check("rst_id", bus.active_id, 0);
        $display("txn reset: speaker=%0b busy=%0b", bus.speaker, bus.busy);

        reset = 1'b0;
        step();
        check("bgm_follow", bus.speaker, 1);
        bus.bgm_in = 1'b0;
        check("bgm_lag", bus.speaker, 1);
        step();
        check("bgm_low", bus.speaker, 0);
        bus.bgm_en = 1'b0;
        bus.bgm_in = 1'b1;
        step();
        check("bgm_mute", bus.speaker, 0);
        bus.bgm_en = 1'b1;
        step();
        check("bgm_unmute", bus.speaker, 1);
        $display("txn bgm passthrough: speaker=%0b", bus.speaker);

        // Single effect: half=3, len=12, then done, 5 silent cycles, BGM.
        pat = 12'b000111000111;
        load(2, 3, 12);
        fire(4'b0100);
        check("single_grant", bus.grant, 1);
        check("single_id", bus.active_id, 2);
        check("single_busy", bus.busy, 1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            check("single_tone", bus.speaker, pat[i]);
            if (i == 1) check("single_grant_pulse", bus.grant, 0);
            if (i == 11) check("single_nodone_early", bus.done, 0);
        end
        step();
        check("single_done", bus.done, 1);
        check("single_done_spk", bus.speaker, 0);
        for (int g = 0; g < GAP; g++) begin
            step();
            check("single_gap_spk", bus.speaker, 0);
            if (g == 0) check("single_done_pulse", bus.done, 0);
        end
        step();
        check("single_bgm_back", bus.speaker, 1);
        check("single_idle", bus.busy, 0);
        $display("txn single effect id=2 half=3 len=12 complete");

        // Simultaneous requests in IDLE.
        load(1, 2, 4);
        load(3, 1, 9);
        fire(4'b1010);
        check("simul_grant", bus.grant, 1);
        check("simul_id", bus.active_id, 1);
        check("simul_drop", bus.drop, 4'b1000);
        steps(3);
        check("simul_nodone", bus.done, 0);
        step();
        check("simul_done", bus.done, 1);
        $display("txn simultaneous req=1010 granted id=%0d", bus.active_id);

        // Request while in GAP aborts the gap.
        step();
        load(3, 2, 3);
        fire(4'b1000);
        check("gapreq_grant", bus.grant, 1);
        check("gapreq_id", bus.active_id, 3);
        check("gapreq_spk", bus.speaker, 1);
        $display("txn request during gap accepted id=%0d", bus.active_id);

        // Request on the completion edge: new (silent) effect starts at once.
        steps(2);
        load(0, 0, 10);
        fire(4'b0001);
        check("back2back_done", bus.done, 1);
        check("back2back_grant", bus.grant, 1);
        check("back2back_id", bus.active_id, 0);
        check("back2back_busy", bus.busy, 1);
        for (int i = 0; i < 9; i++) begin
            check("silent_spk", bus.speaker, 0);
            step();
        end
        check("silent_busy", bus.busy, 1);
        check("silent_nodone", bus.done, 0);
        step();
        check("silent_done", bus.done, 1);
        check("silent_done_spk", bus.speaker, 0);
        steps(GAP + 1);
        check("silent_bgm_back", bus.speaker, 1);
        $display("txn back-to-back and silent effect complete");

        // Preemption of requester 3 by requester 1 at cycle 20.
        load(3, 4, 100);
        fire(4'b1000);
        check("pre_grant3", bus.grant, 1);
        steps(19);
        load(1, 2, 6);
        fire(4'b0010);
        check("pre_grant1", bus.grant, 1);
        check("pre_id", bus.active_id, 1);
        check("pre_spk_restart", bus.speaker, 1);
        check("pre_no_done", bus.done, 0);
        load(2, 1, 5);
        fire(4'b0100);
        check("pre_drop2", bus.drop, 4'b0100);
        check("pre_drop_nogrant", bus.grant, 0);
        check("pre_keep_id", bus.active_id, 1);
        check("pre_keep_tone", bus.speaker, 1);
        steps(4);
        check("pre_nodone_early", bus.done, 0);
        step();
        check("pre_done", bus.done, 1);
        check("pre_id_hold", bus.active_id, 1);
        steps(GAP + 1);
        $display("txn preemption id3->id1, id2 dropped");

        // len=0 behaves as a single cycle.
        load(2, 1, 0);
        fire(4'b0100);
        check("len0_grant", bus.grant, 1);
        check("len0_spk", bus.speaker, 1);
        step();
        check("len0_done", bus.done, 1);
        check("len0_spk_off", bus.speaker, 0);
        steps(GAP + 1);
        $display("txn len=0 effect lasted one cycle");

        // Reset in the middle of an effect.
        load(1, 2, 50);
        fire(4'b0010);
        steps(3);
        reset = 1'b1;
        step();
        check("midrst_busy", bus.busy, 0);
        check("midrst_spk", bus.speaker, 0);
        check("midrst_id", bus.active_id, 0);
        reset = 1'b0;
        load(3, 2, 5);
        fire(4'b1000);
        check("postrst_grant", bus.grant, 1);
        check("postrst_id", bus.active_id, 3);
        check("postrst_spk", bus.speaker, 1);
        $display("txn reset mid-play then new grant id=%0d", bus.active_id);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
